// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the five-stage MIPS pipeline.
//   Owns the program counter, drives the instruction-memory read port and
//   loads the IF/ID register. Stall, jump and branch decisions arrive from
//   downstream and are applied here, together with fetch/stall/flush counters.
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-low reset
//   imem_addr / imem_rdata  combinational instruction-memory read port
//   stall                   hold PC and IF/ID for this cycle
//   jump                    ID decoded a J on IFID_instr
//   branch_taken/_target    redirect request from branch resolution
//   PC                      current fetch address
//   IFID_instr              IF/ID instruction (0 = bubble)
//   IFID_pc_plus4           IF/ID copy of fetch address + 4
//   halted                  sticky out-of-range fetch flag
//   fetch_count             real instructions loaded into IF/ID
//   stall_count             stall cycles honoured
//   flush_count             jump and branch flushes
module fetch_stage #(
    parameter int IMEM_WORDS = 32,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             stall,
    input  logic             jump,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    output logic [31:0]      PC,
    output logic [31:0]      IFID_instr,
    output logic [31:0]      IFID_pc_plus4,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [2:0] {
        ACT_HALT,
        ACT_BRANCH,
        ACT_STALL,
        ACT_JUMP,
        ACT_FAULT,
        ACT_FETCH
    } action_t;

    localparam logic [31:0] PC_LIMIT = 32'(4 * IMEM_WORDS);

    action_t     action;
    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic [31:0] pc_next;
    logic [31:0] instr_next;
    logic [31:0] pc4_next;
    logic        halted_next;
    logic        fetch_inc;
    logic        stall_inc;
    logic        flush_inc;

    assign imem_addr   = PC;
    assign pc_plus4    = PC + 32'd4;
    // J target uses the upper nibble of the J's own PC+4, which IF/ID still holds.
    assign jump_target = {IFID_pc_plus4[31:28], IFID_instr[25:0], 2'b00};

    // One action per edge, strictly prioritised; a stalled jump is simply
    // re-evaluated once stall drops because the J is still sitting in IF/ID.
    always_comb begin
        action = halted            ? ACT_HALT   :
                 branch_taken      ? ACT_BRANCH :
                 stall             ? ACT_STALL  :
                 jump              ? ACT_JUMP   :
                 (PC >= PC_LIMIT)  ? ACT_FAULT  : ACT_FETCH;
    end

    always_comb begin
        pc_next     = PC;
        instr_next  = IFID_instr;
        pc4_next    = IFID_pc_plus4;
        halted_next = halted;
        fetch_inc   = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        case (action)
            ACT_HALT: begin
                instr_next = '0;
            end
            ACT_BRANCH: begin
                pc_next    = {branch_target[31:2], 2'b00};
                instr_next = '0;
                flush_inc  = 1'b1;
            end
            ACT_STALL: begin
                stall_inc = 1'b1;
            end
            ACT_JUMP: begin
                pc_next    = jump_target;
                instr_next = '0;
                flush_inc  = 1'b1;
            end
            ACT_FAULT: begin
                halted_next = 1'b1;
                instr_next  = '0;
            end
            default: begin
                pc_next    = pc_plus4;
                instr_next = imem_rdata;
                pc4_next   = pc_plus4;
                fetch_inc  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            PC            <= '0;
            IFID_instr    <= '0;
            IFID_pc_plus4 <= '0;
            halted        <= 1'b0;
            fetch_count   <= '0;
            stall_count   <= '0;
            flush_count   <= '0;
        end else begin
            PC            <= pc_next;
            IFID_instr    <= instr_next;
            IFID_pc_plus4 <= pc4_next;
            halted        <= halted_next;
            fetch_count   <= fetch_count + CNT_W'(fetch_inc);
            stall_count   <= stall_count + CNT_W'(stall_inc);
            flush_count   <= flush_count + CNT_W'(flush_inc);
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage.
//   Stimulus pushes the hand-computed post-edge state into a queue; a monitor
//   pops and compares it at each falling edge, or on demand between edges.
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        jump;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] PC;
    logic [31:0] IFID_instr;
    logic [31:0] IFID_pc_plus4;
    logic        halted;
    logic [15:0] fetch_count;
    logic [15:0] stall_count;
    logic [15:0] flush_count;

    fetch_stage #(.IMEM_WORDS(32), .CNT_W(16)) dut (
        .clock(clock),
        .reset(reset),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .stall(stall),
        .jump(jump),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .PC(PC),
        .IFID_instr(IFID_instr),
        .IFID_pc_plus4(IFID_pc_plus4),
        .halted(halted),
        .fetch_count(fetch_count),
        .stall_count(stall_count),
        .flush_count(flush_count)
    );

    always #5 clock = ~clock;

    // Program: word 0 is the reset test word, word 8 is J 0x0B (target 44),
    // every other word i is 0x21080000 | i. Out-of-range reads return junk.
    logic [31:0] mem [32];
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h2108_0000 | 32'(i);
        mem[0] = 32'h0208_8020;
        mem[8] = 32'h0800_000B;
    end
    assign imem_rdata = (imem_addr < 32'd128) ? mem[imem_addr[6:2]] : 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] p4;
        logic        h;
        logic [31:0] fc;
        logic [31:0] sc;
        logic [31:0] fl;
    } exp_t;

    exp_t q[$];
    event probe;
    event done_ev;
    logic ending = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_pop = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL item%0d %s: got %h expected %h", n_pop, name, act, exp);
    endtask

    // Monitor: compares DUT outputs against the oldest expectation.
    initial forever begin
        @(negedge clock or probe or done_ev);
        if (ending) begin
            chk("drain", 32'(q.size()), 32'd0);
            $display("%0d/%0d checks passed", n_pass, n_checks);
            $finish;
        end else if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_pop++;
            chk("PC", PC, e.pc);
            chk("imem_addr", imem_addr, e.pc);
            chk("IFID_instr", IFID_instr, e.ins);
            chk("IFID_pc_plus4", IFID_pc_plus4, e.p4);
            chk("halted", 32'(halted), 32'(e.h));
            chk("fetch_count", 32'(fetch_count), e.fc);
            chk("stall_count", 32'(stall_count), e.sc);
            chk("flush_count", 32'(flush_count), e.fl);
        end
    end

    task automatic expect_state(input logic [31:0] pc, ins, p4, input logic h,
                                input logic [31:0] fc, sc, fl);
        exp_t e;
        e.pc = pc; e.ins = ins; e.p4 = p4; e.h = h;
        e.fc = fc; e.sc = sc; e.fl = fl;
        q.push_back(e);
    endtask

    // Drive inputs for the next rising edge and record the state it must produce.
    task automatic step(input logic st, jp, br, input logic [31:0] bt,
                        input logic [31:0] pc, ins, p4, input logic h,
                        input logic [31:0] fc, sc, fl);
        stall = st; jump = jp; branch_taken = br; branch_target = bt;
        expect_state(pc, ins, p4, h, fc, sc, fl);
        @(negedge clock);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc, ins, fc, sc, fl);
        step(1'b0, 1'b0, 1'b0, 32'd0, pc, ins, pc, 1'b0, fc, sc, fl);
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; jump = 1'b0; branch_taken = 1'b0; branch_target = '0;
        #1;
        repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        fetch(4, 32'h0208_8020, 1, 0, 0);
        for (int i = 2; i <= 9; i++)
            fetch(32'(4 * i), (i == 9) ? 32'h0800_000B : (32'h2108_0000 | 32'(i - 1)), 32'(i), 0, 0);
        // jump from IF/ID (J 0x0B, pc+4 = 36) -> 44, then a one-cycle stall
        step(0, 1, 0, 0, 44, 0, 36, 0, 9, 0, 1);
        step(1, 0, 0, 0, 44, 0, 36, 0, 9, 1, 1);
        fetch(48, 32'h2108_000B, 10, 1, 1);
        fetch(52, 32'h2108_000C, 11, 1, 1);
        // branch beats concurrent stall and jump; low target bits dropped
        step(1, 1, 1, 32'd106, 104, 0, 52, 0, 11, 1, 2);
        fetch(108, 32'h2108_001A, 12, 1, 2);
        step(0, 0, 1, 32'd32, 32, 0, 108, 0, 12, 1, 3);
        fetch(36, 32'h0800_000B, 13, 1, 3);
        // jump deferred by a two-cycle stall
        step(1, 1, 0, 0, 36, 32'h0800_000B, 36, 0, 13, 2, 3);
        step(1, 1, 0, 0, 36, 32'h0800_000B, 36, 0, 13, 3, 3);
        step(0, 1, 0, 0, 44, 0, 36, 0, 13, 3, 4);
        for (int i = 0; i < 7; i++)
            fetch(32'(48 + 4 * i), 32'h2108_000B + 32'(i), 32'(14 + i), 3, 4);
        // asynchronous reset between edges at PC=72, stall_count=3
        reset = 1'b0;
        #1;
        expect_state(0, 0, 0, 0, 0, 0, 0);
        ->probe;
        @(negedge clock);
        #1;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        // straight-line run to the end of memory
        for (int i = 1; i <= 32; i++)
            fetch(32'(4 * i),
                  (i == 1) ? 32'h0208_8020 : (i == 9) ? 32'h0800_000B : (32'h2108_0000 | 32'(i - 1)),
                  32'(i), 0, 0);
        step(0, 0, 0, 0, 128, 0, 128, 1, 32, 0, 0);
        step(1, 1, 1, 32'd0, 128, 0, 128, 1, 32, 0, 0);
        step(0, 0, 0, 0, 128, 0, 128, 1, 32, 0, 0);
        ending = 1'b1;
        ->done_ev;
        #100;
        $display("FAIL end: monitor did not finish");
        $fatal(1, "monitor stuck");
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline. It owns the program counter, drives the instruction-memory read port, and loads the IF/ID pipeline register. It applies the stall, jump-flush and branch-flush decisions made downstream, and keeps fetch/stall/flush event counters. Its `PC` and `IFID_instr` outputs are the signals the pipeline trace monitor samples each cycle.

## Interface
- `IMEM_WORDS`, default 32: instruction-memory depth in 32-bit words; legal fetch addresses are 0 .. 4*IMEM_WORDS-4.
- `CNT_W`, default 16: width of each event counter.

Ports:
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low.
- `imem_addr` out 32: equals `PC` (combinational).
- `imem_rdata` in 32: instruction word at `imem_addr`, valid in the same cycle.
- `stall` in 1: load-use hazard; hold PC and IF/ID.
- `jump` in 1: ID has decoded J on `IFID_instr`.
- `branch_taken` in 1: PCSrc from the branch-resolution stage.
- `branch_target` in 32: redirect address, valid when `branch_taken`=1.
- `PC` out 32: current fetch address.
- `IFID_instr` out 32: IF/ID instruction; 0 means bubble.
- `IFID_pc_plus4` out 32: IF/ID copy of fetch address + 4.
- `halted` out 1: sticky out-of-range fetch flag.
- `fetch_count` out CNT_W: count of real instructions loaded into IF/ID.
- `stall_count` out CNT_W: count of stall cycles honoured.
- `flush_count` out CNT_W: count of jump and branch flushes.

## Operation
- Each rising edge performs exactly one action. The action is chosen in this priority order:
  1. **HALTED**: `halted`=1. PC holds, `IFID_instr`<=0, and `IFID_pc_plus4` holds. All inputs are ignored and no counter moves.
  2. **BRANCH**: `branch_taken`=1. PC<={`branch_target`[31:2],2'b00}, `IFID_instr`<=0, `flush_count`+1. This overrides a concurrent `stall` and `jump`; `stall_count` does not move.
  3. **STALL**: `stall`=1. PC, `IFID_instr` and `IFID_pc_plus4` hold, and `stall_count`+1. A concurrent `jump` is deferred: the J stays in IF/ID and is acted on once `stall` drops.
  4. **JUMP**: `jump`=1. PC<={`IFID_pc_plus4`[31:28],`IFID_instr`[25:0],2'b00} and `IFID_instr`<=0. `IFID_pc_plus4` holds, so the J remains recoverable for tracing. `flush_count`+1.
  5. **FAULT**: normal fetch with PC >= 4*IMEM_WORDS. `halted`<=1, PC holds, `IFID_instr`<=0, and no counter moves.
  6. **FETCH**: PC<=PC+4, `IFID_instr`<=`imem_rdata`, `IFID_pc_plus4`<=PC+4, `fetch_count`+1.
- The jump target is computed inside this block from IF/ID contents. The decoder supplies only the `jump` flag.
- A branch to an out-of-range address is accepted; the FAULT fires on the following cycle.
- PC arithmetic is 32-bit modulo 2^32. The counters wrap modulo 2^CNT_W, with no saturation.
- Reset (`reset`=0, asynchronous): PC=0, `IFID_instr`=0, `IFID_pc_plus4`=0, `halted`=0, all counters 0. Assertion mid-operation clears state immediately, without waiting for a clock edge. There is no partial update on the edge coincident with deassertion.

## Timing
- Fetch latency: one cycle. An instruction at address A appears in `IFID_instr` on the edge after PC=A.
- Redirect penalty: branch and jump each insert exactly one zero into IF/ID.
- `imem_addr`=`PC` with no register stage. `imem_rdata` must settle within the same cycle.
- All outputs are registered except `imem_addr`. Inputs are sampled only at the rising edge.
- Back-to-back redirects are legal: branch on cycle n and jump on cycle n+1 give two zeros and `flush_count`+2.
- `stall` held for k cycles gives k identical IF/ID cycles and `stall_count`+k.

## Test plan
- **Reset and first fetch.** Stimulus: `reset`=0 for 4 cycles with imem[0]=0x02088020, then release. Response: during reset, all outputs are 0. After the first edge, `IFID_instr`=0x02088020, `IFID_pc_plus4`=4, PC=4, `fetch_count`=1.
- **Single-cycle stall.** Stimulus: `stall`=1 for one cycle at PC=44. Response: PC stays 44 for two cycles, IF/ID is unchanged, `stall_count`=1. Normal fetch resumes at PC=48.
- **Jump.** Stimulus: `IFID_instr`=0x0800000B, `IFID_pc_plus4`=36, `jump`=1. Response: next PC=44, `IFID_instr`=0, `flush_count`+1. Repeat with `stall`=1 in the same cycle: PC holds, and the jump takes effect on the cycle after `stall` drops.
- **Branch priority.** Stimulus: `branch_taken`=1, `branch_target`=106, with `stall`=1 and `jump`=1 in the same cycle. Response: PC=104 (low bits forced to 00), `IFID_instr`=0, `flush_count`+1, `stall_count` unchanged.
- **Out-of-range halt.** Stimulus: IMEM_WORDS=32, run straight-line code until PC=128. Response: on the next edge `halted`=1, PC=128 and `IFID_instr`=0. A later `branch_taken`=1 with target 0 is ignored. `fetch_count`=32 if no stalls or flushes occurred.
- **Asynchronous reset mid-run.** Stimulus: drop `reset` between clock edges at PC=72 with `stall_count`=3. Response: PC, IF/ID, `halted` and all counters read 0 before the next edge. The first edge after release fetches imem[0].
